apb_master_bridge: RTL and testbench

APB_MASTER_BRIDGE -- requirements
Module: apb_master_bridge

---
 rtl/apb_master_bridge.sv | 177 +++++++++++++++++
 tb/tb_apb_master_bridge.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_master_bridge.sv
// Host command/response to APB master bridge: one transfer in flight, SETUP/ACCESS
// sequencing with a bounded PREADY wait that aborts with a timeout response.
module apb_master_bridge #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        PCLK,
    input  logic        PRESETN,

    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [31:0] cmd_addr,
    input  logic [31:0] cmd_wdata,

    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        rsp_timeout,

    output logic        PSEL,
    output logic        PENABLE,
    output logic        PWRITE,
    output logic [31:0] PADDR,
    output logic [31:0] PWDATA,
    input  logic [31:0] PRDATA,
    input  logic        PREADY,
    input  logic        PSLVERR
);

    localparam int unsigned CNT_W = 8;
    localparam int unsigned DATA_W = 32;
    localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    wait_cnt_q, wait_cnt_d;
    logic [CNT_W-1:0]    wait_cnt_inc;
    logic                cmd_ready_q, cmd_ready_d;
    logic                psel_q, psel_d;
    logic                penable_q, penable_d;
    logic                pwrite_q, pwrite_d;
    logic [DATA_W-1:0]   paddr_q, paddr_d;
    logic [DATA_W-1:0]   pwdata_q, pwdata_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic                rsp_err_q, rsp_err_d;
    logic                rsp_timeout_q, rsp_timeout_d;

    assign wait_cnt_inc = wait_cnt_q + CNT_W'(1);

    // Next-state and registered-output decode; every output is computed one edge ahead.
    always_comb begin
        state_d       = state_q;
        wait_cnt_d    = wait_cnt_q;
        cmd_ready_d   = cmd_ready_q;
        psel_d        = psel_q;
        penable_d     = penable_q;
        pwrite_d      = pwrite_q;
        paddr_d       = paddr_q;
        pwdata_d      = pwdata_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_err_d     = rsp_err_q;
        rsp_timeout_d = rsp_timeout_q;

        case (state_q)
            ST_IDLE: begin
                // cmd_ready_q is 0 only on the first IDLE cycle after reset
                cmd_ready_d = 1'b1;
                if (cmd_valid && cmd_ready_q) begin
                    state_d     = ST_SETUP;
                    cmd_ready_d = 1'b0;
                    paddr_d     = cmd_addr;
                    pwrite_d    = cmd_write;
                    pwdata_d    = cmd_wdata;
                    psel_d      = 1'b1;
                    penable_d   = 1'b0;
                    wait_cnt_d  = '0;
                end
            end

            ST_SETUP: begin
                state_d   = ST_ACCESS;
                penable_d = 1'b1;
            end

            ST_ACCESS: begin
                // Completion takes priority over a timeout reached on the same edge
                if (PREADY) begin
                    state_d       = ST_RESP;
                    psel_d        = 1'b0;
                    penable_d     = 1'b0;
                    rsp_valid_d   = 1'b1;
                    rsp_rdata_d   = pwrite_q ? '0 : PRDATA;
                    rsp_err_d     = PSLVERR;
                    rsp_timeout_d = 1'b0;
                end else if (wait_cnt_inc == TIMEOUT_VAL) begin
                    state_d       = ST_RESP;
                    wait_cnt_d    = wait_cnt_inc;
                    psel_d        = 1'b0;
                    penable_d     = 1'b0;
                    rsp_valid_d   = 1'b1;
                    rsp_rdata_d   = '0;
                    rsp_err_d     = 1'b1;
                    rsp_timeout_d = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_inc;
                end
            end

            ST_RESP: begin
                if (rsp_ready) begin
                    state_d     = ST_IDLE;
                    rsp_valid_d = 1'b0;
                    cmd_ready_d = 1'b1;
                end
            end

            default: begin
                state_d     = ST_IDLE;
                psel_d      = 1'b0;
                penable_d   = 1'b0;
                rsp_valid_d = 1'b0;
                cmd_ready_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            state_q       <= ST_IDLE;
            wait_cnt_q    <= '0;
            cmd_ready_q   <= 1'b0;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            pwrite_q      <= 1'b0;
            paddr_q       <= '0;
            pwdata_q      <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            wait_cnt_q    <= wait_cnt_d;
            cmd_ready_q   <= cmd_ready_d;
            psel_q        <= psel_d;
            penable_q     <= penable_d;
            pwrite_q      <= pwrite_d;
            paddr_q       <= paddr_d;
            pwdata_q      <= pwdata_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_err_q     <= rsp_err_d;
            rsp_timeout_q <= rsp_timeout_d;
        end
    end

    assign cmd_ready   = cmd_ready_q;
    assign PSEL        = psel_q;
    assign PENABLE     = penable_q;
    assign PWRITE      = pwrite_q;
    assign PADDR       = paddr_q;
    assign PWDATA      = pwdata_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_err     = rsp_err_q;
    assign rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Scoreboard bench for apb_master_bridge: host driver, APB completer model and
// response monitor run as separate processes sharing expectation queues.
module tb_apb_master_bridge;

    localparam int unsigned TO = 16;

    logic        PCLK = 1'b0;
    logic        PRESETN = 1'b0;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr, cmd_wdata;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err, rsp_timeout;
    logic        PSEL, PENABLE, PWRITE;
    logic [31:0] PADDR, PWDATA, PRDATA;
    logic        PREADY, PSLVERR;

    apb_master_bridge #(.TIMEOUT_CYCLES(TO)) dut (
        .PCLK(PCLK), .PRESETN(PRESETN),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
        .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA),
        .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    always #5 PCLK = ~PCLK;

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          waits;
        bit          slverr;
        int          stall;
    } txn_t;

    typedef struct {
        logic [31:0] rdata;
        bit          err;
        bit          to;
        int          lat;
        int          stall;
    } rsp_t;

    txn_t plan_q[$];
    rsp_t exp_q[$];
    int   acc_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    always @(posedge PCLK) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference: completer answers after `waits` stalled ACCESS cycles unless the bridge gives up first
    function automatic rsp_t model(input txn_t t);
        rsp_t r;
        if (t.waits >= int'(TO)) begin
            r.rdata = 32'h0; r.err = 1'b1; r.to = 1'b1; r.lat = int'(TO);
        end else begin
            r.rdata = t.wr ? 32'h0 : t.rdata; r.err = t.slverr; r.to = 1'b0; r.lat = t.waits + 1;
        end
        r.stall = t.stall;
        return r;
    endfunction

    function automatic txn_t mk(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [31:0] rdata, input int waits, input bit slverr,
                                input int stall);
        txn_t t;
        t.wr = wr; t.addr = addr; t.wdata = wdata; t.rdata = rdata;
        t.waits = waits; t.slverr = slverr; t.stall = stall;
        return t;
    endfunction

    function automatic txn_t rand_txn();
        txn_t t;
        int sel;
        sel = int'($urandom_range(0, 9));
        t.wr = 1'($urandom_range(0, 1));
        t.addr = $urandom & 32'hFFFF_FFFC;
        t.wdata = $urandom;
        t.rdata = $urandom;
        t.slverr = ($urandom_range(0, 3) == 0);
        t.stall = 0;
        case (sel)
            6: t.waits = int'(TO) - 1;
            7: t.waits = int'(TO);
            8: t.waits = int'($urandom_range(TO + 1, TO + 8));
            9: t.waits = int'($urandom_range(4, TO - 2));
            default: t.waits = int'($urandom_range(0, 3));
        endcase
        return t;
    endfunction

    task automatic chk_reset(input string tag);
        chk({tag, "_cmd_ready"}, 32'(cmd_ready), 32'h0);
        chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'h0);
        chk({tag, "_rsp_rdata"}, rsp_rdata, 32'h0);
        chk({tag, "_rsp_err"}, 32'(rsp_err), 32'h0);
        chk({tag, "_rsp_timeout"}, 32'(rsp_timeout), 32'h0);
        chk({tag, "_psel"}, 32'(PSEL), 32'h0);
        chk({tag, "_penable"}, 32'(PENABLE), 32'h0);
        chk({tag, "_pwrite"}, 32'(PWRITE), 32'h0);
        chk({tag, "_paddr"}, PADDR, 32'h0);
        chk({tag, "_pwdata"}, PWDATA, 32'h0);
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send(input txn_t t, input bit expect_rsp);
        int n;
        n = 0;
        plan_q.push_back(t);
        if (expect_rsp) exp_q.push_back(model(t));
        cmd_valid = 1'b1; cmd_write = t.wr; cmd_addr = t.addr; cmd_wdata = t.wdata;
        while (!cmd_ready && n < 400) begin
            @(negedge PCLK);
            n++;
        end
        if (n >= 400) chk("cmd_accept_wait", 32'h0, 32'h1);
        else if (expect_rsp) acc_q.push_back(cyc + 1);
        @(negedge PCLK);
        cmd_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 2000) begin
            @(negedge PCLK);
            n++;
        end
        if (n >= 2000) chk("drain_wait", 32'(exp_q.size()), 32'h0);
    endtask

    // APB completer model
    txn_t        cur;
    bit          active = 1'b0;
    int          acc_cnt = 0;
    bit          have_last = 1'b0;
    logic [31:0] last_addr, last_wdata;

    initial begin
        PREADY = 1'b0; PSLVERR = 1'b0; PRDATA = 32'h0;
        forever begin
            @(negedge PCLK);
            if (!PRESETN) begin
                active = 1'b0; have_last = 1'b0; PREADY = 1'b0;
            end else if (PSEL && !PENABLE) begin
                if (plan_q.size() == 0) begin
                    chk("unexpected_setup", 32'h1, 32'h0);
                end else begin
                    cur = plan_q.pop_front();
                    active = 1'b1; acc_cnt = 0;
                    chk("setup_paddr", PADDR, cur.addr);
                    chk("setup_pwrite", 32'(PWRITE), 32'(cur.wr));
                    chk("setup_pwdata", PWDATA, cur.wdata);
                    have_last = 1'b1; last_addr = cur.addr; last_wdata = cur.wdata;
                end
                PREADY = 1'($urandom_range(0, 1)); PSLVERR = 1'($urandom_range(0, 1)); PRDATA = $urandom;
            end else if (PSEL && PENABLE && active) begin
                chk("access_paddr", PADDR, cur.addr);
                chk("access_pwrite", 32'(PWRITE), 32'(cur.wr));
                chk("access_pwdata", PWDATA, cur.wdata);
                if (acc_cnt == cur.waits) begin
                    PREADY = 1'b1; PSLVERR = cur.slverr; PRDATA = cur.rdata;
                end else begin
                    PREADY = 1'b0; PSLVERR = 1'b1; PRDATA = $urandom;
                end
                acc_cnt++;
            end else begin
                if (active) begin
                    chk("penable_cycles", 32'(acc_cnt),
                        32'((cur.waits >= int'(TO)) ? int'(TO) : cur.waits + 1));
                    active = 1'b0;
                end
                if (!PSEL && have_last) begin
                    chk("paddr_hold", PADDR, last_addr);
                    chk("pwdata_hold", PWDATA, last_wdata);
                end
                PREADY = 1'($urandom_range(0, 1)); PSLVERR = 1'($urandom_range(0, 1)); PRDATA = $urandom;
            end
        end
    end

    // Response monitor
    rsp_t        e;
    int          a_cyc, stall;
    logic [31:0] got_rdata;
    logic        got_err, got_to;

    initial begin
        rsp_ready = 1'b0;
        forever begin
            @(negedge PCLK);
            if (PRESETN && rsp_valid) begin
                got_rdata = rsp_rdata; got_err = rsp_err; got_to = rsp_timeout;
                stall = 0;
                if (exp_q.size() == 0 || acc_q.size() == 0) begin
                    chk("unexpected_rsp", 32'h1, 32'h0);
                end else begin
                    e = exp_q.pop_front();
                    a_cyc = acc_q.pop_front();
                    chk("rsp_rdata", got_rdata, e.rdata);
                    chk("rsp_err", 32'(got_err), 32'(e.err));
                    chk("rsp_timeout", 32'(got_to), 32'(e.to));
                    chk("rsp_latency", 32'(cyc - a_cyc), 32'(e.lat + 1));
                    stall = e.stall;
                end
                chk("apb_idle_in_resp", 32'({PSEL, PENABLE}), 32'h0);
                if (stall == 0) stall = int'($urandom_range(0, 2));
                rsp_ready = 1'b0;
                repeat (stall) begin
                    @(negedge PCLK);
                    chk("hold_rsp_valid", 32'(rsp_valid), 32'h1);
                    chk("hold_rsp_rdata", rsp_rdata, got_rdata);
                    chk("hold_rsp_flags", 32'({rsp_err, rsp_timeout}), 32'({got_err, got_to}));
                    chk("hold_cmd_ready", 32'(cmd_ready), 32'h0);
                    chk("hold_no_psel", 32'(PSEL), 32'h0);
                end
                rsp_ready = 1'b1;
                @(negedge PCLK);
                rsp_ready = 1'b0;
                chk("rsp_valid_drop", 32'(rsp_valid), 32'h0);
            end
        end
    end

    initial begin
        int n;
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 32'h0; cmd_wdata = 32'h0;
        PRESETN = 1'b0;
        repeat (3) @(negedge PCLK);
        chk_reset("rst");
        PRESETN = 1'b1;
        chk("cmd_ready_before_edge", 32'(cmd_ready), 32'h0);
        @(posedge PCLK);
        #1 chk("cmd_ready_after_rst", 32'(cmd_ready), 32'h1);
        @(negedge PCLK);

        send(mk(1'b1, 32'h0000_0004, 32'hA5A5_1234, 32'h1357_9BDF, 0, 1'b0, 0), 1'b1);
        send(mk(1'b0, 32'h0000_0008, 32'h0, 32'hDEAD_BEEF, 3, 1'b0, 0), 1'b1);
        send(mk(1'b0, 32'h0000_000C, 32'h0, 32'h0BAD_F00D, 2, 1'b1, 0), 1'b1);
        send(mk(1'b0, 32'h0000_0010, 32'h0, 32'h7777_7777, int'(TO), 1'b0, 0), 1'b1);
        send(mk(1'b0, 32'h0000_0014, 32'h0, 32'h1234_5678, int'(TO) - 1, 1'b0, 0), 1'b1);
        send(mk(1'b1, 32'h0000_0018, 32'hFFFF_0000, 32'h0, int'(TO) + 4, 1'b0, 0), 1'b1);
        send(mk(1'b1, 32'h0000_001C, 32'h1111_2222, 32'h0, 0, 1'b0, 5), 1'b1);
        send(mk(1'b0, 32'h0000_0020, 32'h0, 32'h3333_4444, 1, 1'b0, 0), 1'b1);

        for (int i = 0; i < 150; i++) begin
            repeat ($urandom_range(0, 2)) @(negedge PCLK);
            send(rand_txn(), 1'b1);
        end
        drain();

        // Reset while the completer is stalling in ACCESS
        send(mk(1'b0, 32'h0000_0040, 32'h0, 32'h5555_AAAA, 8, 1'b0, 0), 1'b0);
        n = 0;
        while (!PENABLE && n < 20) begin
            @(negedge PCLK);
            n++;
        end
        chk("mid_rst_reached_access", 32'(PENABLE), 32'h1);
        @(negedge PCLK);
        #2 PRESETN = 1'b0;
        #1 chk_reset("mid_rst");
        @(negedge PCLK);
        @(negedge PCLK);
        chk("mid_rst_no_rsp", 32'(rsp_valid), 32'h0);
        plan_q.delete();
        PRESETN = 1'b1;
        @(posedge PCLK);
        #1 chk("cmd_ready_after_mid_rst", 32'(cmd_ready), 32'h1);
        @(negedge PCLK);
        send(mk(1'b0, 32'h0000_0044, 32'h0, 32'hCAFE_F00D, 1, 1'b0, 0), 1'b1);
        drain();
        repeat (10) @(negedge PCLK);

        chk("queues_empty", 32'(plan_q.size() + exp_q.size() + acc_q.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
